// File: rtl/irb_pkg.sv
// Shared types and helpers for the inverted-residual-block scheduler.
// Phase encoding, DMA opcodes, and the phase-to-opcode decode.
package irb_pkg;

  // Channels per group; kept equal to dma_pkg::Npar.
  localparam int DMA_NPAR = 8;

  typedef enum logic [3:0] {
    IDLE,
    LD_FMI,
    LD_KEX,
    EXP,
    LD_KDW,
    DW,
    LD_KPR,
    PROJ,
    ST_FMO,
    FINISHED
  } phase_t;

  typedef enum logic [2:0] {
    OP_LD_FMI = 3'd0,
    OP_LD_KEX = 3'd1,
    OP_LD_KDW = 3'd2,
    OP_LD_KPR = 3'd3,
    OP_ST_FMO = 3'd4
  } dma_op_t;

  function automatic logic is_dma_phase(phase_t p);
    return p inside {LD_FMI, LD_KEX, LD_KDW, LD_KPR, ST_FMO};
  endfunction

  function automatic dma_op_t dma_op_of(phase_t p);
    case (p)
      LD_KEX:  return OP_LD_KEX;
      LD_KDW:  return OP_LD_KDW;
      LD_KPR:  return OP_LD_KPR;
      ST_FMO:  return OP_ST_FMO;
      default: return OP_LD_FMI;
    endcase
  endfunction

endpackage

// File: rtl/irb_if.sv
// Engine-side bus of the scheduler: DMA, conv1x1 and depthwise start/finish
// handshakes plus their sideband. master = scheduler, slave = engines.
interface irb_if
  import irb_pkg::*;
#(
  parameter int TW = 8
) ();
  logic          dma_start;
  dma_op_t       dma_op;
  logic [TW-1:0] dma_tx;
  logic [TW-1:0] dma_ty;
  logic [TW-1:0] dma_grp;
  logic          dma_finish;
  logic          conv_start;
  logic [10:0]   conv_nif;
  logic          conv_proj;
  logic          conv_acc;
  logic          conv_finish;
  logic          dw_start;
  logic          dw_finish;

  modport master (
    output dma_start, dma_op, dma_tx, dma_ty, dma_grp,
    output conv_start, conv_nif, conv_proj, conv_acc,
    output dw_start,
    input  dma_finish, conv_finish, dw_finish
  );

  modport slave (
    input  dma_start, dma_op, dma_tx, dma_ty, dma_grp,
    input  conv_start, conv_nif, conv_proj, conv_acc,
    input  dw_start,
    output dma_finish, conv_finish, dw_finish
  );
endinterface

// File: rtl/irb_tile_cnt.sv
// Nested tile/group counter: grp innermost, then tx, then ty.
// inc_grp wraps grp to 0 after the last group; inc_tile advances tx then ty.
module irb_tile_cnt #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc_grp,
  input  logic          inc_tile,
  input  logic [TW-1:0] ngrp,
  input  logic [TW-1:0] ntx,
  input  logic [TW-1:0] nty,
  output logic [TW-1:0] tx,
  output logic [TW-1:0] ty,
  output logic [TW-1:0] grp,
  output logic          last_grp,
  output logic          last_tile
);
  localparam logic [TW-1:0] ONE = {{(TW-1){1'b0}}, 1'b1};

  logic last_tx, last_ty;

  // Compare against count-1 so a count of 2**TW-1 never needs a wider counter.
  assign last_grp  = (grp == ngrp - ONE);
  assign last_tx   = (tx == ntx - ONE);
  assign last_ty   = (ty == nty - ONE);
  assign last_tile = last_tx && last_ty;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx  <= '0;
      ty  <= '0;
      grp <= '0;
    end else if (clr) begin
      tx  <= '0;
      ty  <= '0;
      grp <= '0;
    end else begin
      if (inc_grp) grp <= last_grp ? '0 : grp + ONE;
      if (inc_tile) begin
        if (last_tx) begin
          tx <= '0;
          ty <= last_ty ? '0 : ty + ONE;
        end else begin
          tx <= tx + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/irb_scheduler.sv
// Sequencer for one inverted residual block: per tile, load input, then per
// group expand/depthwise/project, then store; engines run one at a time.
module irb_scheduler
  import irb_pkg::*;
#(
  parameter int NPAR = DMA_NPAR,
  parameter int TW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [10:0]   cfg_nif,
  input  logic [TW-1:0] cfg_ngrp,
  input  logic [TW-1:0] cfg_ntx,
  input  logic [TW-1:0] cfg_nty,
  irb_if.master         bus,
  output logic          busy,
  output logic          done
);
  phase_t        state, state_nxt;
  logic          first_q;
  logic [10:0]   nif_q;
  logic [TW-1:0] ngrp_q, ntx_q, nty_q;
  logic [TW-1:0] tx, ty, grp;
  logic          clr, inc_grp, inc_tile, last_grp, last_tile;
  logic          phase_fin, fin_ok, zero_cfg, entering;

  irb_tile_cnt #(.TW(TW)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .inc_grp   (inc_grp),
    .inc_tile  (inc_tile),
    .ngrp      (ngrp_q),
    .ntx       (ntx_q),
    .nty       (nty_q),
    .tx        (tx),
    .ty        (ty),
    .grp       (grp),
    .last_grp  (last_grp),
    .last_tile (last_tile)
  );

  assign zero_cfg = (cfg_ngrp == '0) || (cfg_ntx == '0) || (cfg_nty == '0);
  assign entering = (state_nxt != state);

  // Only the active phase's own engine may end it, and never on its start cycle.
  always_comb begin
    case (state)
      LD_FMI, LD_KEX, LD_KDW, LD_KPR, ST_FMO: phase_fin = bus.dma_finish;
      EXP, PROJ:                              phase_fin = bus.conv_finish;
      DW:                                     phase_fin = bus.dw_finish;
      default:                                phase_fin = 1'b0;
    endcase
  end
  assign fin_ok = phase_fin && !first_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    inc_grp   = 1'b0;
    inc_tile  = 1'b0;
    case (state)
      IDLE: if (start) begin
        clr       = 1'b1;
        state_nxt = zero_cfg ? FINISHED : LD_FMI;
      end
      LD_FMI: if (fin_ok) state_nxt = LD_KEX;
      LD_KEX: if (fin_ok) state_nxt = EXP;
      EXP:    if (fin_ok) state_nxt = LD_KDW;
      LD_KDW: if (fin_ok) state_nxt = DW;
      DW:     if (fin_ok) state_nxt = LD_KPR;
      LD_KPR: if (fin_ok) state_nxt = PROJ;
      PROJ: if (fin_ok) begin
        inc_grp   = 1'b1;
        state_nxt = last_grp ? ST_FMO : LD_KEX;
      end
      ST_FMO: if (fin_ok) begin
        inc_tile  = 1'b1;
        state_nxt = last_tile ? FINISHED : LD_FMI;
      end
      FINISHED: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      first_q        <= 1'b0;
      bus.dma_start  <= 1'b0;
      bus.conv_start <= 1'b0;
      bus.dw_start   <= 1'b0;
      done           <= 1'b0;
      nif_q          <= '0;
      ngrp_q         <= '0;
      ntx_q          <= '0;
      nty_q          <= '0;
    end else begin
      state          <= state_nxt;
      first_q        <= entering;
      bus.dma_start  <= entering && is_dma_phase(state_nxt);
      bus.conv_start <= entering && (state_nxt == EXP || state_nxt == PROJ);
      bus.dw_start   <= entering && (state_nxt == DW);
      done           <= (state == FINISHED);
      if (state == IDLE && start) begin
        nif_q  <= cfg_nif;
        ngrp_q <= cfg_ngrp;
        ntx_q  <= cfg_ntx;
        nty_q  <= cfg_nty;
      end
    end
  end

  // Sideband decodes straight from state and counters, which only move on
  // phase changes, so it holds steady for the whole phase.
  assign bus.dma_op    = dma_op_of(state);
  assign bus.dma_tx    = tx;
  assign bus.dma_ty    = ty;
  assign bus.dma_grp   = grp;
  assign bus.conv_proj = (state == PROJ);
  assign bus.conv_acc  = (state == PROJ) && (grp != '0);
  assign bus.conv_nif  = (state == EXP)  ? nif_q :
                         (state == PROJ) ? 11'(NPAR) : 11'd0;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_irb_scheduler.sv
// Scoreboard bench for irb_scheduler: a model of the phase sequence fills an
// expected-event queue; a negedge monitor pops and compares each issued start/done.
module tb_irb_scheduler;
  import irb_pkg::*;

  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [10:0]   cfg_nif = '0;
  logic [TW-1:0] cfg_ngrp = '0, cfg_ntx = '0, cfg_nty = '0;
  logic          busy, done;

  irb_if #(.TW(TW)) bus ();

  irb_scheduler #(.NPAR(8), .TW(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_nif  (cfg_nif),
    .cfg_ngrp (cfg_ngrp),
    .cfg_ntx  (cfg_ntx),
    .cfg_nty  (cfg_nty),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Event signature: kind(0 dma,1 conv,2 dw,3 done), op, tx, ty, grp, nif, proj, acc.
  function automatic logic [63:0] ev(input int kind, input logic [2:0] op,
                                     input logic [7:0] tx, input logic [7:0] ty,
                                     input logic [7:0] grp, input logic [10:0] nif,
                                     input logic proj, input logic acc);
    return {23'd0, 2'(kind), op, tx, ty, grp, nif, proj, acc};
  endfunction

  task automatic push_run(input int nif, input int ngrp, input int ntx, input int nty);
    for (int y = 0; y < nty; y++) begin
      for (int x = 0; x < ntx; x++) begin
        exp_q.push_back(ev(0, 3'd0, 8'(x), 8'(y), 8'd0, 11'd0, 1'b0, 1'b0));
        for (int g = 0; g < ngrp; g++) begin
          exp_q.push_back(ev(0, 3'd1, 8'(x), 8'(y), 8'(g), 11'd0, 1'b0, 1'b0));
          exp_q.push_back(ev(1, 3'd0, 8'd0, 8'd0, 8'd0, 11'(nif), 1'b0, 1'b0));
          exp_q.push_back(ev(0, 3'd2, 8'(x), 8'(y), 8'(g), 11'd0, 1'b0, 1'b0));
          exp_q.push_back(ev(2, 3'd0, 8'd0, 8'd0, 8'd0, 11'd0, 1'b0, 1'b0));
          exp_q.push_back(ev(0, 3'd3, 8'(x), 8'(y), 8'(g), 11'd0, 1'b0, 1'b0));
          exp_q.push_back(ev(1, 3'd0, 8'd0, 8'd0, 8'd0, 11'd8, 1'b1, g != 0));
        end
        exp_q.push_back(ev(0, 3'd4, 8'(x), 8'(y), 8'd0, 11'd0, 1'b0, 1'b0));
      end
    end
    exp_q.push_back(ev(3, 3'd0, 8'd0, 8'd0, 8'd0, 11'd0, 1'b0, 1'b0));
  endtask

  // Monitor: samples mid-cycle and compares each issue against the queue head.
  always @(negedge clk) begin
    logic [63:0] got;
    if (rst && (bus.dma_start || bus.conv_start || bus.dw_start || done)) begin
      if (bus.dma_start || bus.conv_start || bus.dw_start) start_cnt++;
      check("one_issue_per_cycle",
            64'($countones({bus.dma_start, bus.conv_start, bus.dw_start, done}) <= 1), 64'd1);
      if (bus.dma_start)
        got = ev(0, bus.dma_op, bus.dma_tx, bus.dma_ty, bus.dma_grp, 11'd0, 1'b0, 1'b0);
      else if (bus.conv_start)
        got = ev(1, 3'd0, 8'd0, 8'd0, 8'd0, bus.conv_nif, bus.conv_proj, bus.conv_acc);
      else if (bus.dw_start)
        got = ev(2, 3'd0, 8'd0, 8'd0, 8'd0, 11'd0, 1'b0, 1'b0);
      else
        got = ev(3, 3'd0, 8'd0, 8'd0, 8'd0, 11'd0, 1'b0, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0h, expected no event (t=%0t)", got, $time);
      end else begin
        check("event", got, exp_q.pop_front());
      end
    end
  end

  function automatic logic issued(input int kind);
    case (kind)
      1:       return bus.dma_start;
      2:       return bus.conv_start;
      default: return bus.dw_start;
    endcase
  endfunction

  task automatic drive_fin(input int kind, input logic val);
    case (kind)
      1:       bus.dma_finish = val;
      2:       bus.conv_finish = val;
      default: bus.dw_finish = val;
    endcase
  endtask

  task automatic pulse_start(input int nif, input int ngrp, input int ntx, input int nty);
    cfg_nif  = 11'(nif);
    cfg_ngrp = 8'(ngrp);
    cfg_ntx  = 8'(ntx);
    cfg_nty  = 8'(nty);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_start(input int kind, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (issued(kind)) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check($sformatf("start_seen_kind%0d", kind), 64'(ok), 64'd1);
  endtask

  task automatic serve(input int kind);
    bit ok;
    wait_start(kind, ok);
    if (ok) begin
      @(posedge clk); #1;
      drive_fin(kind, 1'b1);
      @(posedge clk); #1;
      drive_fin(kind, 1'b0);
    end
  endtask

  // Answers every start one cycle later; n counts cycles from the first phase cycle to done.
  task automatic serve_until_done(input int budget, input bit poke,
                                  output int n, output int busy_low);
    int pend;
    pend = 0;
    n = 0;
    busy_low = 0;
    while (!done && n < budget) begin
      bus.dma_finish  = (pend == 1);
      bus.conv_finish = (pend == 2);
      bus.dw_finish   = (pend == 3);
      pend = bus.dma_start ? 1 : bus.conv_start ? 2 : bus.dw_start ? 3 : 0;
      if (!busy) busy_low++;
      if (poke && n == 10) begin
        start = 1'b1; cfg_nif = 11'd5; cfg_ngrp = 8'd1; cfg_ntx = 8'd1; cfg_nty = 8'd1;
      end
      if (poke && n == 11) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    bus.dma_finish  = 1'b0;
    bus.conv_finish = 1'b0;
    bus.dw_finish   = 1'b0;
  endtask

  initial begin
    int n, bl, s0;
    bit ok;
    bus.dma_finish  = 1'b0;
    bus.conv_finish = 1'b0;
    bus.dw_finish   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("reset_outputs", 64'({bus.dma_start, bus.conv_start, bus.dw_start, done, bus.dma_op,
          bus.conv_nif, bus.conv_proj, bus.conv_acc, bus.dma_tx, bus.dma_ty, bus.dma_grp}), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single tile, single group, minimum latency
    push_run(16, 1, 1, 1);
    pulse_start(16, 1, 1, 1);
    serve_until_done(100, 1'b0, n, bl);
    check("latency_1x1x1", 64'(n), 64'd17);
    check("busy_low_cycles_1x1x1", 64'(bl), 64'd0);
    @(posedge clk); #1;
    check("done_is_pulse", 64'(done), 64'd0);
    check("queue_drained_1x1x1", 64'(exp_q.size()), 64'd0);

    // 3 groups on a 2x2 tile grid; a start with new cfg lands mid-run
    push_run(24, 3, 2, 2);
    pulse_start(24, 3, 2, 2);
    serve_until_done(1000, 1'b1, n, bl);
    check("latency_3x2x2", 64'(n), 64'd161);
    check("busy_low_cycles_3x2x2", 64'(bl), 64'd0);
    @(posedge clk); #1;
    check("queue_drained_3x2x2", 64'(exp_q.size()), 64'd0);

    // Foreign and early finishes during EXP must not advance the phase
    push_run(16, 1, 1, 1);
    pulse_start(16, 1, 1, 1);
    serve(1);
    serve(1);
    wait_start(2, ok);
    bus.conv_finish = 1'b1;
    @(posedge clk); #1;
    bus.conv_finish = 1'b0;
    bus.dw_finish   = 1'b1;
    bus.dma_finish  = 1'b1;
    @(posedge clk); #1;
    bus.dw_finish   = 1'b0;
    bus.dma_finish  = 1'b0;
    s0 = start_cnt;
    repeat (3) @(posedge clk); #1;
    check("spurious_no_advance", 64'(start_cnt), 64'(s0));
    check("spurious_busy", 64'(busy), 64'd1);
    check("spurious_exp_nif_held", 64'(bus.conv_nif), 64'd16);
    check("spurious_exp_mode_held", 64'(bus.conv_proj), 64'd0);
    bus.conv_finish = 1'b1;
    @(posedge clk); #1;
    bus.conv_finish = 1'b0;
    serve(1);
    serve(3);
    serve(1);
    serve(2);
    serve(1);
    serve_until_done(10, 1'b0, n, bl);
    check("spurious_done_after_finished", 64'(n), 64'd1);
    @(posedge clk); #1;
    check("queue_drained_spurious", 64'(exp_q.size()), 64'd0);

    // Zero tile columns: straight to FINISHED, no engine activity
    exp_q.push_back(ev(3, 3'd0, 8'd0, 8'd0, 8'd0, 11'd0, 1'b0, 1'b0));
    s0 = start_cnt;
    pulse_start(16, 1, 0, 1);
    serve_until_done(20, 1'b0, n, bl);
    check("zero_ntx_done_latency", 64'(n), 64'd1);
    check("zero_ntx_busy_in_finished", 64'(bl), 64'd0);
    @(posedge clk); #1;
    check("zero_ntx_no_starts", 64'(start_cnt), 64'(s0));
    check("queue_drained_zero_ntx", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset during DW, then a stale dw_finish, then a normal run
    push_run(16, 1, 1, 1);
    pulse_start(16, 1, 1, 1);
    serve(1);
    serve(1);
    serve(2);
    serve(1);
    wait_start(3, ok);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", 64'({bus.dma_start, bus.conv_start, bus.dw_start, done,
          bus.dma_op, bus.conv_nif, bus.conv_proj, bus.conv_acc, bus.dma_tx, bus.dma_ty,
          bus.dma_grp}), 64'd0);
    check("async_reset_busy", 64'(busy), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    s0 = start_cnt;
    bus.dw_finish = 1'b1;
    @(posedge clk); #1;
    bus.dw_finish = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("stale_finish_idle", 64'(busy), 64'd0);
    check("stale_finish_no_starts", 64'(start_cnt), 64'(s0));
    push_run(16, 1, 1, 1);
    pulse_start(16, 1, 1, 1);
    serve_until_done(100, 1'b0, n, bl);
    check("latency_after_reset", 64'(n), 64'd17);
    @(posedge clk); #1;
    check("queue_drained_final", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irb_scheduler.md
Name: irb_scheduler

Overview:
- Top-level sequencer for one inverted residual block: expansion 1x1 convolution, depthwise 3x3, then projection 1x1 convolution, tile by tile.
- Issues DMA transfers for input tiles, kernels and output tiles.
- Issues start pulses to the shared 1x1 convolution unit (expansion and projection modes) and to the depthwise unit, and waits for their finish pulses.
- Sits between the layer controller (cfg/start/done) and the DMA, conv1x1 and depthwise engines.

Parameters:
- NPAR, 8: channels per group (equal to dma_pkg Npar).
- TW, 8: counter width for tiles and groups.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that launches the block; ignored unless IDLE
- cfg_nif  in  11  input channels of the block
- cfg_ngrp  in  TW  expansion channel groups (Nexp/NPAR)
- cfg_ntx  in  TW  tile columns
- cfg_nty  in  TW  tile rows
- dma_start  out  1  one-cycle DMA request
- dma_op  out  3  0 LD_FMI, 1 LD_KEX, 2 LD_KDW, 3 LD_KPR, 4 ST_FMO
- dma_tx, dma_ty  out  TW  current tile coordinates
- dma_grp  out  TW  current group index
- dma_finish  in  1  DMA done pulse
- conv_start  out  1  one-cycle start to the conv1x1 unit
- conv_nif  out  11  channel count passed to conv1x1
- conv_proj  out  1  0 = expansion mode, 1 = projection mode
- conv_acc  out  1  projection accumulates onto previous partial sum
- conv_finish  in  1  conv1x1 done pulse
- dw_start  out  1  one-cycle start to the depthwise unit
- dw_finish  in  1  depthwise done pulse
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when the block completes

Behaviour:
- Reset: state = IDLE; all outputs 0; counters tx, ty, grp = 0; latched config registers = 0.
- start in IDLE latches all cfg_* inputs.
  - If cfg_ngrp, cfg_ntx or cfg_nty is 0: go to FINISHED.
  - Otherwise: go to LD_FMI with tx = ty = grp = 0.
  - start in any other state is ignored.
- Phase states and their issued unit:
  - LD_FMI -> DMA op 0
  - LD_KEX -> DMA op 1
  - EXP -> conv, conv_proj = 0, conv_nif = nif
  - LD_KDW -> DMA op 2
  - DW -> depthwise unit
  - LD_KPR -> DMA op 3
  - PROJ -> conv, conv_proj = 1, conv_nif = NPAR, conv_acc = (grp != 0)
  - ST_FMO -> DMA op 4
- Issue rule: on the first cycle in each phase state, the phase's start output is high (registered) for exactly one cycle. All other start outputs are low.
- Sideband outputs (dma_op, dma_tx/ty/grp, conv_nif, conv_proj, conv_acc) are valid from the start cycle until that phase's finish and stay stable throughout the phase.
- Completion: the phase's own finish input is sampled only on cycles after the start cycle. When it is sampled high, the next state is entered on the next edge.
  - Finish pulses from other units are ignored.
  - A finish arriving on the start cycle is ignored.
- Transitions:
  - LD_FMI -> LD_KEX -> EXP -> LD_KDW -> DW -> LD_KPR -> PROJ.
  - PROJ: if grp < ngrp-1, then grp++ and go to LD_KEX; else go to ST_FMO.
  - ST_FMO: grp = 0. Then:
    - if tx < ntx-1: tx++, go to LD_FMI;
    - else if ty < nty-1: tx = 0, ty++, go to LD_FMI;
    - else go to FINISHED.
  - FINISHED: done = 1 for one cycle, then IDLE.
- Minimum latency: 2 cycles per phase when every finish arrives the cycle after start.
  - Total = 2*(1 + 6*ngrp + 1)*ntx*nty + 1 (FINISHED) cycles from the first LD_FMI cycle.
- Counter widths:
  - Compare with latched values minus 1 at TW bits.
  - ngrp = 255 is legal, and no counter wraps.
- Reset mid-operation returns immediately to IDLE with all outputs 0. An in-flight finish pulse after reset is ignored.
- busy is a combinational decode of the state.
- done and every start output are registered.

Decomposition:
- Shared package irb_pkg:
  - phase_t enum: IDLE, LD_FMI, LD_KEX, EXP, LD_KDW, DW, LD_KPR, PROJ, ST_FMO, FINISHED.
  - dma_op_t enum with the encodings listed above.
  - NPAR is taken from dma_pkg::Npar.
- One sub-module, irb_tile_cnt: the tx/ty/grp nested counter, with inc_grp, inc_tile and clr inputs and last_grp and last_tile outputs.
- The FSM and the issue/sideband registers stay in irb_scheduler.

Test Plan:
- ngrp=1, ntx=1, nty=1, finishes returned 1 cycle after each start:
  - dma_op sequence is 0,1,-(EXP),2,-(DW),3,-(PROJ),4.
  - done arrives 17 cycles after the first LD_FMI cycle.
  - busy is high throughout.
- ngrp=3, ntx=2, nty=2:
  - 4 ST_FMO transfers at (tx,ty) = (0,0),(1,0),(0,1),(1,1).
  - 12 PROJ issues, with conv_acc = 0,1,1 per tile.
  - conv_nif = nif (e.g. 24) in EXP and 8 in PROJ.
- Spurious pulses: dw_finish and dma_finish pulsed during EXP, and conv_finish on the conv_start cycle.
  - Expected: state stays EXP until a later conv_finish.
- start pulsed while busy, with cfg changed:
  - Expected: ignored, and the latched cfg is unchanged.
- cfg_ntx=0:
  - Expected: done one cycle after the FINISHED entry, and no DMA or conv starts.
- rst low during DW:
  - Expected: all outputs 0 asynchronously and state IDLE.
  - A dw_finish after reset release does nothing.
  - A subsequent start runs normally.
